// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL supervisor / reset sequencer.
// The state encoding and saturating debug counter helper live here.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST,
    WAIT_LOCK,
    RELEASE,
    RUN
  } state_t;

  localparam int EVT_CNT_W = 8;

  // Debug counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [EVT_CNT_W-1:0] sat_inc(input logic [EVT_CNT_W-1:0] v);
    return (&v) ? v : v + EVT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear, used to bring
// the PLL LOCK signal into the reference clock domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL supervisor: pulses the PLL reset, filters LOCK with a timeout, releases
// staged downstream resets and re-sequences on lock loss or software request.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int NUM_RST             = 3,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_FILT_CYCLES    = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGE_GAP           = 16,
  parameter int LOSS_FILT_CYCLES    = 4
) (
  input  logic                 clkin,
  input  logic                 reset_n,
  input  logic                 pll_lock,
  input  logic                 req_reset,
  output logic                 pll_reset,
  output logic [NUM_RST-1:0]   rst_out_n,
  output logic                 ready,
  output logic [EVT_CNT_W-1:0] relock_cnt,
  output logic [EVT_CNT_W-1:0] timeout_cnt
);

  localparam int RST_W  = $clog2(PLL_RST_CYCLES + 1);
  localparam int FILT_W = $clog2(LOCK_FILT_CYCLES + 1);
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);
  localparam int LOSS_W = $clog2(LOSS_FILT_CYCLES + 1);

  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST = FILT_W'(LOCK_FILT_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST = LOSS_W'(LOSS_FILT_CYCLES - 1);
  localparam logic [NUM_RST-1:0] BIT0      = NUM_RST'(1);

  state_t            state;
  logic              lock_s;
  logic [RST_W-1:0]  rst_cnt;
  logic [FILT_W-1:0] filt;
  logic [TMO_W-1:0]  tmo;
  logic [GAP_W-1:0]  gap;
  logic [LOSS_W-1:0] loss;

  logic lock_done;
  logic go_timeout;
  logic go_relock;

  sync2 u_lock_sync (
    .clk   (clkin),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Lock qualification beats the timeout when both complete on one edge.
  assign lock_done  = (state == WAIT_LOCK) && lock_s && (filt == FILT_LAST);
  assign go_timeout = (state == WAIT_LOCK) && !lock_done && (tmo == TMO_LAST);
  assign go_relock  = ((state != PLL_RST) && req_reset)
                    || ((state == RELEASE) && !lock_s)
                    || ((state == RUN) && !lock_s && (loss == LOSS_LAST));

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state       <= PLL_RST;
      pll_reset   <= 1'b1;
      rst_out_n   <= '0;
      ready       <= 1'b0;
      relock_cnt  <= '0;
      timeout_cnt <= '0;
      rst_cnt     <= '0;
      filt        <= '0;
      tmo         <= '0;
      gap         <= '0;
      loss        <= '0;
    end else if (go_relock || go_timeout) begin
      // Every re-entry asserts all downstream resets at once.
      state     <= PLL_RST;
      pll_reset <= 1'b1;
      rst_out_n <= '0;
      ready     <= 1'b0;
      rst_cnt   <= '0;
      if (go_relock) relock_cnt  <= sat_inc(relock_cnt);
      else           timeout_cnt <= sat_inc(timeout_cnt);
    end else begin
      case (state)
        PLL_RST: begin
          filt <= '0;
          tmo  <= '0;
          if (req_reset) begin
            rst_cnt <= '0;
          end else if (rst_cnt == RST_LAST) begin
            rst_cnt   <= '0;
            pll_reset <= 1'b0;
            state     <= WAIT_LOCK;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end

        WAIT_LOCK: begin
          tmo <= tmo + TMO_W'(1);
          if (lock_done) begin
            state     <= RELEASE;
            rst_out_n <= BIT0;
            gap       <= '0;
          end else if (lock_s) begin
            filt <= filt + FILT_W'(1);
          end else begin
            filt <= '0;
          end
        end

        RELEASE: begin
          // Release bits fill upward from bit 0, one per STAGE_GAP cycles.
          if (rst_out_n[NUM_RST-1]) begin
            state <= RUN;
            ready <= 1'b1;
            loss  <= '0;
          end else if (gap == GAP_LAST) begin
            gap       <= '0;
            rst_out_n <= (rst_out_n << 1) | BIT0;
          end else begin
            gap <= gap + GAP_W'(1);
          end
        end

        RUN: begin
          loss <= lock_s ? '0 : loss + LOSS_W'(1);
        end

        default: state <= PLL_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: expected timings come from
// arithmetic on the sequence rules plus a lock-window model for acquisition.
module tb_pll_reset_seq;

  localparam int N      = 3;
  localparam int P_RST  = 4;
  localparam int P_FILT = 8;
  localparam int P_TMO  = 32;
  localparam int P_GAP  = 2;
  localparam int P_LOSS = 2;
  localparam int T_REL  = P_RST + P_FILT;
  localparam int T_RDY  = T_REL + (N - 1) * P_GAP + 1;
  localparam int PER    = P_RST + P_TMO;

  logic         clkin;
  logic         reset_n   = 1'b0;
  logic         pll_lock  = 1'b0;
  logic         req_reset = 1'b0;
  logic         pll_reset;
  logic [N-1:0] rst_out_n;
  logic         ready;
  logic [7:0]   relock_cnt;
  logic [7:0]   timeout_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit lk [0:255];

  pll_reset_seq #(
    .NUM_RST             (N),
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_FILT_CYCLES    (P_FILT),
    .LOCK_TIMEOUT_CYCLES (P_TMO),
    .STAGE_GAP           (P_GAP),
    .LOSS_FILT_CYCLES    (P_LOSS)
  ) dut (
    .clkin       (clkin),
    .reset_n     (reset_n),
    .pll_lock    (pll_lock),
    .req_reset   (req_reset),
    .pll_reset   (pll_reset),
    .rst_out_n   (rst_out_n),
    .ready       (ready),
    .relock_cnt  (relock_cnt),
    .timeout_cnt (timeout_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clkin);
    #2;
    cyc++;
  endtask

  task automatic start(input bit lock0);
    reset_n   = 1'b0;
    req_reset = 1'b0;
    pll_lock  = lock0;
    repeat (2) @(posedge clkin);
    #2;
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_ready: ready=%b after %0d cycles, want 1", tag, ready, n);
    end
  endtask

  // Clean-start release pattern k edges after reset release.
  function automatic logic [N-1:0] staged(input int k);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = (k >= T_REL + i * P_GAP);
    return v;
  endfunction

  function automatic bit lk_at(input int i);
    if (i < 0) return 1'b0;
    if (i > 255) return lk[255];
    return lk[i];
  endfunction

  // Lock driven during cycle i is seen by the sequencer three edges later.
  // Release is the first edge, within an attempt's timeout window, whose
  // preceding P_FILT observed lock samples were all high.
  function automatic void model_acquire(output int rel, output int tmos);
    int w;
    bit ok;
    rel  = -1;
    tmos = 0;
    w    = P_RST;
    for (int a = 0; a < 8 && rel < 0; a++) begin
      for (int e = w + P_FILT; e <= w + P_TMO && rel < 0; e++) begin
        ok = 1'b1;
        for (int j = 0; j < P_FILT; j++) if (!lk_at(e - 3 - j)) ok = 1'b0;
        if (ok) rel = e;
      end
      if (rel < 0) begin
        tmos++;
        w += PER;
      end
    end
  endfunction

  task automatic test_reset();
    reset_n   = 1'b0;
    req_reset = 1'b1;
    pll_lock  = 1'b1;
    repeat (3) @(posedge clkin);
    #2;
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pll_reset: got %b want 1", pll_reset); end
    checks++; if (rst_out_n !== '0) begin errors++; $display("FAIL reset_rst_out_n: got %b want 000", rst_out_n); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (relock_cnt !== 8'd0) begin errors++; $display("FAIL reset_relock_cnt: got %0d want 0", relock_cnt); end
    checks++; if (timeout_cnt !== 8'd0) begin errors++; $display("FAIL reset_timeout_cnt: got %0d want 0", timeout_cnt); end
    req_reset = 1'b0;
  endtask

  task automatic test_clean_start();
    start(1'b1);
    for (int k = 0; k <= T_RDY + 3; k++) begin
      if (k > 0) tick();
      checks++;
      if (pll_reset !== (k < P_RST)) begin
        errors++; $display("FAIL clean_pll_reset @%0d: got %b want %b", k, pll_reset, (k < P_RST));
      end
      checks++;
      if (rst_out_n !== staged(k)) begin
        errors++; $display("FAIL clean_rst_out_n @%0d: got %b want %b", k, rst_out_n, staged(k));
      end
      checks++;
      if (ready !== (k >= T_RDY)) begin
        errors++; $display("FAIL clean_ready @%0d: got %b want %b", k, ready, (k >= T_RDY));
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    n = $urandom_range(3, 4);
    start(1'b0);
    for (int k = 0; k <= n * PER; k++) begin
      if (k > 0) tick();
      checks++;
      if (pll_reset !== ((k % PER) < P_RST)) begin
        errors++; $display("FAIL timeout_pll_reset @%0d: got %b want %b", k, pll_reset, ((k % PER) < P_RST));
      end
      checks++;
      if (timeout_cnt !== 8'(k / PER)) begin
        errors++; $display("FAIL timeout_cnt @%0d: got %0d want %0d", k, timeout_cnt, k / PER);
      end
      checks++;
      if (rst_out_n !== '0) begin
        errors++; $display("FAIL timeout_rst_out_n @%0d: got %b want 000", k, rst_out_n);
      end
    end
  endtask

  task automatic test_acquire();
    int rel, tmos, seen, seen_tmo, r, g;
    logic [N-1:0] seen_rst, one;
    one = N'(1);
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) lk[i] = 1'b1;
      case (t)
        0: lk[7] = 1'b0;
        1: for (int i = 0; i < 26; i++) lk[i] = 1'b0;
        2: for (int i = 0; i < 27; i++) lk[i] = 1'b0;
        default: begin
          r = $urandom_range(0, 90);
          for (int i = 0; i < r; i++) lk[i] = 1'b0;
          g = $urandom_range(0, 3);
          for (int i = 0; i < g; i++) lk[r + $urandom_range(0, 12)] = 1'b0;
        end
      endcase
      model_acquire(rel, tmos);
      start(lk[0]);
      seen     = -1;
      seen_tmo = -1;
      seen_rst = '0;
      for (int k = 0; k < 250 && seen < 0; k++) begin
        if (k > 0) tick();
        if (rst_out_n[0] === 1'b1) begin
          seen     = k;
          seen_tmo = int'(timeout_cnt);
          seen_rst = rst_out_n;
        end
        pll_lock = lk[k];
      end
      checks++;
      if (seen != rel) begin
        errors++; $display("FAIL acquire_release_edge t%0d: got %0d want %0d", t, seen, rel);
      end
      checks++;
      if (seen_tmo != tmos) begin
        errors++; $display("FAIL acquire_timeout_cnt t%0d: got %0d want %0d", t, seen_tmo, tmos);
      end
      checks++;
      if (seen_rst !== one) begin
        errors++; $display("FAIL acquire_first_stage t%0d: got %b want %b", t, seen_rst, one);
      end
    end
  endtask

  task automatic test_lock_loss();
    int d, exp_relock;
    bit drop, exp_rdy;
    start(1'b1);
    exp_relock = 0;
    wait_ready("loss_init");
    for (int it = 0; it < 10; it++) begin
      d = (it == 0) ? 1 : (it == 1) ? P_LOSS : $urandom_range(1, 4);
      drop = (d >= P_LOSS);
      pll_lock = 1'b0;
      for (int k = 1; k <= P_LOSS + 3; k++) begin
        tick();
        if (k == d) pll_lock = 1'b1;
        exp_rdy = !(drop && k >= P_LOSS + 2);
        checks++;
        if (ready !== exp_rdy) begin
          errors++; $display("FAIL loss_ready it%0d d%0d k%0d: got %b want %b", it, d, k, ready, exp_rdy);
        end
        if (drop && k == P_LOSS + 2) begin
          checks++;
          if (rst_out_n !== '0 || pll_reset !== 1'b1) begin
            errors++; $display("FAIL loss_reassert it%0d: rst_out_n=%b pll_reset=%b want 000/1", it, rst_out_n, pll_reset);
          end
        end
      end
      if (drop) exp_relock++;
      checks++;
      if (relock_cnt !== 8'(exp_relock)) begin
        errors++; $display("FAIL loss_relock_cnt it%0d: got %0d want %0d", it, relock_cnt, exp_relock);
      end
      wait_ready("loss");
    end
  endtask

  task automatic test_sw_request();
    int j, r, fall, rise;
    start(1'b1);
    wait_ready("sw_init");
    j = $urandom_range(0, 3);
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    r = cyc;
    checks++;
    if (rst_out_n !== '0 || ready !== 1'b0 || pll_reset !== 1'b1) begin
      errors++; $display("FAIL sw_immediate: rst_out_n=%b ready=%b pll_reset=%b want 000/0/1", rst_out_n, ready, pll_reset);
    end
    checks++;
    if (relock_cnt !== 8'd1) begin
      errors++; $display("FAIL sw_relock_cnt: got %0d want 1", relock_cnt);
    end
    if (j > 0) begin
      repeat (j - 1) tick();
      req_reset = 1'b1;
      tick();
      req_reset = 1'b0;
    end
    fall = -1;
    rise = -1;
    for (int k = 0; k < 60 && rise < 0; k++) begin
      tick();
      if (fall < 0 && pll_reset === 1'b0) fall = cyc - r;
      if (ready === 1'b1) rise = cyc - r;
    end
    checks++;
    if (fall != j + P_RST) begin
      errors++; $display("FAIL sw_pll_reset_fall j%0d: got +%0d want +%0d", j, fall, j + P_RST);
    end
    checks++;
    if (rise != j + T_RDY) begin
      errors++; $display("FAIL sw_ready_rise j%0d: got +%0d want +%0d", j, rise, j + T_RDY);
    end
    checks++;
    if (relock_cnt !== 8'd1) begin
      errors++; $display("FAIL sw_relock_after j%0d: got %0d want 1", j, relock_cnt);
    end
  endtask

  task automatic test_release_loss();
    int dd;
    dd = $urandom_range(T_REL - 2, T_REL + 2);
    start(1'b1);
    for (int k = 1; k <= dd + 3; k++) begin
      tick();
      if (k == dd) pll_lock = 1'b0;
      if (k == dd + 1) pll_lock = 1'b1;
      if (k < dd + 3) begin
        checks++;
        if (rst_out_n !== staged(k)) begin
          errors++; $display("FAIL relloss_stage @%0d: got %b want %b", k, rst_out_n, staged(k));
        end
      end
    end
    checks++;
    if (rst_out_n !== '0 || pll_reset !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL relloss_abort drop@%0d: rst_out_n=%b pll_reset=%b ready=%b want 000/1/0", dd, rst_out_n, pll_reset, ready);
    end
    checks++;
    if (relock_cnt !== 8'd1) begin
      errors++; $display("FAIL relloss_relock_cnt: got %0d want 1", relock_cnt);
    end
  endtask

  task automatic test_saturation_async();
    int n_rel, guard;
    start(1'b1);
    wait_ready("sat_init");
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      repeat (P_LOSS + 2) tick();
      pll_lock = 1'b1;
      n_rel = (i + 1 > 255) ? 255 : i + 1;
      if (i % 50 == 0 || i >= 250) begin
        checks++;
        if (relock_cnt !== 8'(n_rel)) begin
          errors++; $display("FAIL sat_relock_cnt after %0d losses: got %0d want %0d", i + 1, relock_cnt, n_rel);
        end
      end
      wait_ready("sat");
    end
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    checks++;
    if (relock_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_hold: got %0d want 255", relock_cnt);
    end
    guard = 0;
    while (rst_out_n !== N'(1) && guard < 40) begin
      tick();
      guard++;
    end
    checks++;
    if (rst_out_n !== N'(1)) begin
      errors++; $display("FAIL async_reach_release: rst_out_n=%b want 001", rst_out_n);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (pll_reset !== 1'b1 || rst_out_n !== '0 || ready !== 1'b0) begin
      errors++; $display("FAIL async_outputs: pll_reset=%b rst_out_n=%b ready=%b want 1/000/0", pll_reset, rst_out_n, ready);
    end
    checks++;
    if (relock_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin
      errors++; $display("FAIL async_counters: relock=%0d timeout=%0d want 0/0", relock_cnt, timeout_cnt);
    end
    req_reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (pll_reset !== 1'b1 || rst_out_n !== '0 || ready !== 1'b0 || relock_cnt !== 8'd0) begin
      errors++; $display("FAIL async_hold: pll_reset=%b rst_out_n=%b ready=%b relock=%0d", pll_reset, rst_out_n, ready, relock_cnt);
    end
    req_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_timeout();
    test_acquire();
    test_lock_loss();
    test_sw_request();
    test_release_loss();
    test_saturation_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
